// File: rtl/sqrt_scheduler_pkg.sv
// rtl/sqrt_scheduler_pkg.sv - shared constants and FSM state type for the sqrt scheduler
// Purpose: default operand/result widths, fractional bit count and state codes.
package sqrt_scheduler_pkg;

    localparam int IN_W_DEF  = 8;
    localparam int OUT_W_DEF = 16;
    localparam int FRAC_BITS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sqrt_scheduler_if.sv
// rtl/sqrt_scheduler_if.sv - request/response bundle between requesters and the sqrt scheduler
// Ports (signals):
//   req_valid/req_data/req_ready : per-requester operand handshake, requester i in req_data[i*IN_W +: IN_W]
//   rsp_valid/rsp_ready/rsp_data/rsp_id : result handshake with owning requester index
//   busy : scheduler is computing or holding a result
//   master = requester/consumer side, slave = scheduler side
interface sqrt_scheduler_if
    import sqrt_scheduler_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
);
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ*IN_W-1:0] req_data;
    logic [N_REQ-1:0]      req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [OUT_W-1:0]      rsp_data;
    logic [ID_W-1:0]       rsp_id;
    logic                  busy;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, busy
    );
endinterface

// File: rtl/sqrt_scheduler_rr_arbiter.sv
// rtl/sqrt_scheduler_rr_arbiter.sv - round-robin grant selection for the sqrt scheduler
// Ports:
//   req        in  N_REQ  request vector
//   last_grant in  ID_W   index granted most recently; search starts one above it
//   enable     in  1      grants are only produced when high
//   grant      out N_REQ  one-hot grant (all zero when disabled or no request)
//   grant_idx  out ID_W   index of the granted requester (last_grant when none)
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_grant,
    input  logic             enable,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx
);
    logic found;

    // Walk offsets 1..N_REQ so the previous winner is considered last.
    always_comb begin
        grant     = '0;
        grant_idx = last_grant;
        found     = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            int idx;
            idx = (int'(last_grant) + k) % N_REQ;
            if (enable && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
            end
        end
    end
endmodule

// File: rtl/sqrt_scheduler.sv
// rtl/sqrt_scheduler.sv - shared bit-serial Q8.8 square-root engine with round-robin requesters
// Ports:
//   clk  in  rising-edge clock
//   rst  in  synchronous active-high reset
//   bus  slave modport of sqrt_scheduler_if (requests in, result + id out, busy)
// Result is floor(sqrt(op) * 2^FRAC_BITS), one result bit per CALC cycle, MSB first.
module sqrt_scheduler
    import sqrt_scheduler_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    sqrt_scheduler_if.slave bus
);
    state_t             state;
    logic [IN_W-1:0]    op;
    logic [OUT_W-1:0]   acc;
    logic [OUT_W-1:0]   bit_mask;
    logic [ID_W-1:0]    last_grant;

    logic [N_REQ-1:0]   grant;
    logic [ID_W-1:0]    grant_idx;
    logic               accept;

    logic [OUT_W-1:0]   trial;
    logic [2*OUT_W-1:0] sq;
    logic [2*OUT_W-1:0] target;
    logic [OUT_W-1:0]   acc_next;

    // Arbitration is combinational so a requester sees its grant in the same
    // cycle it raises valid; reset masks it so a coincident handshake is lost.
    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .enable     ((state == IDLE) && !rst),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    assign bus.req_ready = grant;
    assign accept        = |(bus.req_valid & grant);

    // Full-width square so the top trial bits are never lost in the compare.
    assign trial    = acc | bit_mask;
    assign sq       = {{OUT_W{1'b0}}, trial} * {{OUT_W{1'b0}}, trial};
    assign target   = (2*OUT_W)'({op, {(2*FRAC_BITS){1'b0}}});
    assign acc_next = (sq <= target) ? trial : acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            op            <= '0;
            acc           <= '0;
            bit_mask      <= '0;
            last_grant    <= ID_W'(N_REQ - 1);
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_id    <= '0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op         <= bus.req_data[grant_idx*IN_W +: IN_W];
                        bus.rsp_id <= grant_idx;
                        last_grant <= grant_idx;
                        acc        <= '0;
                        bit_mask   <= {1'b1, {(OUT_W-1){1'b0}}};
                        bus.busy   <= 1'b1;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    acc      <= acc_next;
                    bit_mask <= bit_mask >> 1;
                    if (bit_mask[0]) begin
                        bus.rsp_data  <= acc_next;
                        bus.rsp_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    bus.rsp_valid <= 1'b0;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sqrt_scheduler.sv
// tb/tb_sqrt_scheduler.sv - directed self-checking bench for sqrt_scheduler
module tb_sqrt_scheduler;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    sqrt_scheduler_if #(.N_REQ(4), .ID_W(2), .IN_W(8), .OUT_W(16)) bus ();

    sqrt_scheduler #(.N_REQ(4), .ID_W(2), .IN_W(8), .OUT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operand from requester r and collect its response (rsp_ready=1).
    task automatic run_op(input int r, input logic [7:0] v, output logic [3:0] gr,
                          output logic [15:0] d, output logic [1:0] id,
                          output int lat, output bit to);
        int n;
        to = 1'b0; gr = '0; d = '0; id = '0; lat = 0; n = 0;
        @(negedge clk);
        bus.req_data[r*8 +: 8] = v;
        bus.req_valid[r] = 1'b1;
        bus.rsp_ready = 1'b1;
        #1;
        while (bus.req_ready[r] !== 1'b1 && n < 60) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 60) begin
            to = 1'b1; bus.req_valid[r] = 1'b0; return;
        end
        gr = bus.req_ready;
        @(negedge clk);
        bus.req_valid[r] = 1'b0;
        while (bus.rsp_valid !== 1'b1 && lat < 60) begin
            @(negedge clk); lat++;
        end
        if (lat >= 60) begin
            to = 1'b1; return;
        end
        d  = bus.rsp_data;
        id = bus.rsp_id;
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_data = {8'd49, 8'd36, 8'd25, 8'd16};
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready got=%b exp=0000", bus.req_ready); end
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
        total++; if (bus.rsp_data !== 16'h0000) begin bad++; $display("FAIL reset_rsp_data got=%h exp=0000", bus.rsp_data); end
        total++; if (bus.rsp_id !== 2'd0) begin bad++; $display("FAIL reset_rsp_id got=%0d exp=0", bus.rsp_id); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        rst = 1'b0;
        #1;
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL reset_first_grant got=%b exp=0001", bus.req_ready); end
        bus.req_valid = 4'h0;
    endtask

    task automatic test_single();
        logic [3:0] gr; logic [15:0] d; logic [1:0] id; int lat; bit to;
        run_op(0, 8'd4, gr, d, id, lat, to);
        total++; if (to) begin bad++; $display("FAIL single_timeout got=timeout exp=response"); end
        total++; if (gr !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b exp=0001", gr); end
        total++; if (d !== 16'h0200) begin bad++; $display("FAIL single_data got=%h exp=0200", d); end
        total++; if (id !== 2'd0) begin bad++; $display("FAIL single_id got=%0d exp=0", id); end
        total++; if (lat !== 16) begin bad++; $display("FAIL single_latency got=%0d exp=16", lat); end
    endtask

    task automatic test_values();
        logic [7:0]  vin [5] = '{8'd0, 8'd1, 8'd2, 8'd100, 8'd255};
        logic [15:0] vexp [5] = '{16'h0000, 16'h0100, 16'h016A, 16'h0A00, 16'h0FF7};
        logic [3:0] gr; logic [15:0] d; logic [1:0] id; int lat; bit to;
        for (int i = 0; i < 5; i++) begin
            run_op(i % 4, vin[i], gr, d, id, lat, to);
            total++; if (to) begin bad++; $display("FAIL values_timeout in=%0d got=timeout exp=response", vin[i]); end
            total++; if (d !== vexp[i]) begin bad++; $display("FAIL values_data in=%0d got=%h exp=%h", vin[i], d, vexp[i]); end
            total++; if (id !== 2'(i % 4)) begin bad++; $display("FAIL values_id in=%0d got=%0d exp=%0d", vin[i], id, i % 4); end
        end
    endtask

    task automatic test_sweep();
        logic [3:0] gr; logic [15:0] d; logic [1:0] id; int lat; bit to;
        int r;
        r = 0;
        for (int v = 0; v < 256; v++) begin
            while ((r + 1) * (r + 1) <= v * 65536) r++;
            run_op(0, 8'(v), gr, d, id, lat, to);
            total++;
            if (to || d !== 16'(r)) begin
                bad++; $display("FAIL sweep in=%0d got=%h exp=%h timeout=%0d", v, d, 16'(r), to);
            end
        end
    endtask

    task automatic test_rotation();
        logic [15:0] exp_d [4] = '{16'h0400, 16'h0500, 16'h0600, 16'h0700};
        int n;
        rst = 1'b1;
        bus.req_valid = 4'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.req_data = {8'd49, 8'd36, 8'd25, 8'd16};
        bus.req_valid = 4'hF;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1; n = 0;
            while (bus.req_ready === 4'b0000 && n < 40) begin @(negedge clk); #1; n++; end
            total++; if (bus.req_ready !== 4'(1 << (k % 4))) begin bad++; $display("FAIL rotation_grant k=%0d got=%b exp=%b", k, bus.req_ready, 4'(1 << (k % 4))); end
            @(negedge clk); n = 0;
            while (bus.rsp_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
            if (k == 4) bus.req_valid = 4'h0;
            total++; if (bus.rsp_id !== 2'(k % 4)) begin bad++; $display("FAIL rotation_id k=%0d got=%0d exp=%0d", k, bus.rsp_id, k % 4); end
            total++; if (bus.rsp_data !== exp_d[k % 4]) begin bad++; $display("FAIL rotation_data k=%0d got=%h exp=%h", k, bus.rsp_data, exp_d[k % 4]); end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        bus.req_data = {8'd49, 8'd36, 8'd9, 8'd16};
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0010;
        #1; n = 0;
        while (bus.req_ready[1] !== 1'b1 && n < 40) begin @(negedge clk); #1; n++; end
        @(negedge clk);
        bus.req_valid = 4'b0001;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_timeout got=%b exp=1", bus.rsp_valid); end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            total++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h0300 || bus.rsp_id !== 2'd1 ||
                bus.req_ready !== 4'b0000 || bus.busy !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold c=%0d got=v%b d%h id%0d rdy%b busy%b exp=v1 d0300 id1 rdy0000 busy1",
                         c, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.req_ready, bus.busy);
            end
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk); #1;
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b exp=0", bus.rsp_valid); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL bp_release_busy got=%b exp=0", bus.busy); end
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL bp_release_grant got=%b exp=0001", bus.req_ready); end
        bus.req_valid = 4'h0;
    endtask

    task automatic test_reset_mid();
        int n; int seen;
        @(negedge clk);
        bus.req_data = {8'd49, 8'd64, 8'd9, 8'd16};
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b0100;
        #1; n = 0;
        while (bus.req_ready[2] !== 1'b1 && n < 40) begin @(negedge clk); #1; n++; end
        @(negedge clk);
        bus.req_valid = 4'h0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", bus.rsp_valid); end
        seen = 0;
        for (int c = 0; c < 25; c++) begin @(negedge clk); if (bus.rsp_valid === 1'b1) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL rstmid_stale got=%0d exp=0", seen); end
        bus.req_valid = 4'b1001;
        #1;
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL rstmid_grant got=%b exp=0001", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 4'h0;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        total++; if (bus.rsp_id !== 2'd0 || bus.rsp_data !== 16'h0400) begin bad++; $display("FAIL rstmid_rsp got=id%0d d%h exp=id0 d0400", bus.rsp_id, bus.rsp_data); end
        @(negedge clk);
    endtask

    task automatic test_drop();
        int n; int seen;
        @(negedge clk);
        bus.req_data = {8'd49, 8'd36, 8'd9, 8'd16};
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b0010;
        #1; n = 0;
        while (bus.req_ready[1] !== 1'b1 && n < 40) begin @(negedge clk); #1; n++; end
        @(negedge clk);
        bus.req_valid = 4'b1100;
        repeat (4) @(negedge clk);
        bus.req_valid = 4'b1000;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        total++; if (bus.rsp_id !== 2'd1 || bus.rsp_data !== 16'h0300) begin bad++; $display("FAIL drop_first got=id%0d d%h exp=id1 d0300", bus.rsp_id, bus.rsp_data); end
        @(negedge clk); #1;
        total++; if (bus.req_ready !== 4'b1000) begin bad++; $display("FAIL drop_grant got=%b exp=1000", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 4'h0;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        total++; if (bus.rsp_id !== 2'd3 || bus.rsp_data !== 16'h0700) begin bad++; $display("FAIL drop_second got=id%0d d%h exp=id3 d0700", bus.rsp_id, bus.rsp_data); end
        @(negedge clk);
        seen = 0;
        for (int c = 0; c < 25; c++) begin @(negedge clk); if (bus.rsp_valid === 1'b1) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL drop_extra_rsp got=%0d exp=0", seen); end
    endtask

    task automatic test_reset_handshake();
        int seen;
        @(negedge clk);
        bus.req_valid = 4'b0001;
        rst = 1'b1;
        @(negedge clk);
        bus.req_valid = 4'h0;
        rst = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rsths_busy got=%b exp=0", bus.busy); end
        seen = 0;
        for (int c = 0; c < 20; c++) begin @(negedge clk); if (bus.rsp_valid === 1'b1) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL rsths_rsp got=%0d exp=0", seen); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_data = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_values();
        test_sweep();
        test_rotation();
        test_backpressure();
        test_reset_mid();
        test_drop();
        test_reset_handshake();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
